// File: rtl/hack_io_pkg.sv
// Shared types and constants for the Hack I/O blocks (UART receiver and friends).
package hack_io_pkg;

  // Receiver FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

  // 12.5 MHz / 115200 baud, rounded to the nearest whole cycle.
  localparam int CLKS_PER_BIT_115200 = 109;

  // Bit positions of the status flags inside rx_word.
  localparam int NOT_EMPTY_BIT = 15;
  localparam int OVERRUN_BIT   = 14;
  localparam int FRAME_ERR_BIT = 13;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. DEPTH must be a power of two so
// the pointers wrap naturally. A pop on an empty FIFO is ignored; a push into a
// full FIFO is dropped (reported on overflow) unless a pop frees a slot in the
// same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             not_empty,
  output logic             overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full;
  logic             push_en;
  logic             pop_en;

  // Qualify the strobes, advance pointers/count and present the head word.
  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    full      = (count_q == CW'(DEPTH));
    not_empty = (count_q != '0);
    pop_en    = pop & not_empty;
    push_en   = push & (~full | pop_en);
    overflow  = push & ~push_en;
    wr_ptr_d  = push_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop_en  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d   = count_q;
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    dout = not_empty ? mem_q[rd_ptr_q] : '0;
  end

  // Pointer and occupancy registers.
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write port.
  // NOTE: the array has no reset; count gates the output, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_rx_io.sv
// 8N1 UART receiver feeding a small FIFO, exposing a 16-bit status/data word to
// the memory-mapped I/O bridge. Start bit is confirmed at mid-bit, data and stop
// bits are then sampled one bit period apart. Overrun and framing errors are
// sticky until clr_err; a new error in the same cycle as clr_err keeps the flag.
module uart_rx_io
  import hack_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic        rd_pop,
  input  logic        clr_err,
  output logic [15:0] rx_word,
  output logic        rx_irq_led
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;

  uart_rx_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     shift_q, shift_d;
  logic           sync1_q, sync2_q;
  logic           rx_prev_q;
  logic [2:0]     rx_vld_q, rx_vld_d;
  logic           overrun_q, overrun_d;
  logic           frame_err_q, frame_err_d;
  logic           rx_s;
  logic           fall;
  logic           mid_tick;
  logic           bit_tick;
  logic           push;
  logic           frame_set;
  logic           fifo_overflow;
  logic           fifo_not_empty;
  logic [7:0]     fifo_head;

  // rx_vld_q marks when sync2 and rx_prev hold real pin samples rather than
  // reset values, so a line held low through reset cannot fake a start edge.
  assign rx_s     = sync2_q;
  assign rx_vld_d = {rx_vld_q[1:0], 1'b1};
  assign fall     = rx_vld_q[2] & rx_prev_q & ~rx_s;
  assign mid_tick = (cnt_q == CW'(HALF - 1));
  assign bit_tick = (cnt_q == CW'(CLKS_PER_BIT - 1));

  // Two-flop synchronizer plus the previous-sample register for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_vld_q  <= '0;
    end else begin
      sync1_q   <= rx;
      sync2_q   <= sync1_q;
      rx_prev_q <= rx_s;
      rx_vld_q  <= rx_vld_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fall) state_d = START;
      START:   if (mid_tick) state_d = rx_s ? IDLE : DATA;
      DATA:    if (bit_tick && idx_q == 3'd7) state_d = STOP;
      STOP:    if (bit_tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: bit timer, bit index, shift register, push and frame-error events.
  always_comb begin
    cnt_d     = cnt_q + CW'(1);
    idx_d     = idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
      end
      START: begin
        idx_d = '0;
        if (mid_tick) cnt_d = '0;
      end
      DATA: begin
        if (bit_tick) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
        end
      end
      STOP: begin
        if (bit_tick) begin
          cnt_d     = '0;
          push      = rx_s;
          frame_set = ~rx_s;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  // Datapath registers of the receiver.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Sticky error flags: a set event wins over a simultaneous clear.
  always_comb begin
    overrun_d   = fifo_overflow | (overrun_q & ~clr_err);
    frame_err_d = frame_set     | (frame_err_q & ~clr_err);
  end

  // Error flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .din       (shift_q),
    .pop       (rd_pop),
    .dout      (fifo_head),
    .not_empty (fifo_not_empty),
    .overflow  (fifo_overflow)
  );

  // Assemble the bridge-visible status/data word.
  always_comb begin
    rx_word                = '0;
    rx_word[NOT_EMPTY_BIT] = fifo_not_empty;
    rx_word[OVERRUN_BIT]   = overrun_q;
    rx_word[FRAME_ERR_BIT] = frame_err_q;
    rx_word[7:0]           = fifo_head;
    rx_irq_led             = fifo_not_empty;
  end

endmodule

// File: tb/tb_uart_rx_io.sv
// Directed bench for uart_rx_io: 8N1 frames at 109 clk/bit, glitch rejection,
// framing error and break, FIFO overflow, push/pop collisions and mid-frame reset.
module tb_uart_rx_io;
  import hack_io_pkg::*;

  localparam int BIT = 109;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic        rd_pop;
  logic        clr_err;
  logic [15:0] rx_word;
  logic        rx_irq_led;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_io #(
    .CLKS_PER_BIT (BIT),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rd_pop     (rd_pop),
    .clr_err    (clr_err),
    .rx_word    (rx_word),
    .rx_irq_led (rx_irq_led)
  );

  always #5 clk = ~clk;

  // Count rising edges; all bench activity happens on falling edges.
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_edge(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one 8N1 frame starting at the next falling edge; abort_at >= 0 stops
  // driving at that bit-time offset and leaves the line at its current level.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int abort_at);
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    for (int i = 0; i < 10 * BIT; i++) begin
      @(negedge clk);
      if (i == abort_at) return;
      rx = bits[i / BIT];
    end
  endtask

  // Frame with optional rd_pop / clr_err strobes in the cycle the byte is pushed
  // (start edge seen at e0+3, stop sample at e0+3+1035).
  task automatic frame_strobe(input logic [7:0] d, input logic do_pop, input logic do_clr);
    int e0;
    e0 = cyc + 1;
    fork
      send_frame(d, 1'b1, -1);
      begin
        wait_edge(e0 + 1037);
        rd_pop  = do_pop;
        clr_err = do_clr;
        @(negedge clk);
        rd_pop  = 1'b0;
        clr_err = 1'b0;
      end
    join
  endtask

  task automatic pop_once();
    @(negedge clk);
    rd_pop = 1'b1;
    @(negedge clk);
    rd_pop = 1'b0;
  endtask

  task automatic clear_errors();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  initial begin
    int e0;
    reset   = 1'b1;
    rx      = 1'b1;
    rd_pop  = 1'b0;
    clr_err = 1'b0;
    idle(4);
    check("reset_word", rx_word, 16'h0000);
    check("reset_led", {15'b0, rx_irq_led}, 16'h0000);
    check("reset_state", 16'(dut.state_q), 16'(IDLE));
    reset = 1'b0;
    idle(10);

    // Plain frame 0x41 with latency check around T0+1036.
    e0 = cyc + 1;
    fork
      send_frame(8'h41, 1'b1, -1);
      begin
        wait_edge(e0 + 3 + 1034);
        check("lat_early", rx_word, 16'h0000);
        wait_edge(e0 + 3 + 1036);
        check("rx_41", rx_word, 16'h8041);
        check("led_on", {15'b0, rx_irq_led}, 16'h0001);
      end
    join
    pop_once();
    check("pop_41", rx_word, 16'h0000);
    check("led_off", {15'b0, rx_irq_led}, 16'h0000);
    idle(20);

    // 30-cycle low glitch: rejected at the mid-bit sample.
    e0 = cyc + 1;
    @(negedge clk);
    rx = 1'b0;
    idle(30);
    rx = 1'b1;
    wait_edge(e0 + 3 + 10);
    check("glitch_start", 16'(dut.state_q), 16'(START));
    wait_edge(e0 + 3 + 55);
    check("glitch_idle", 16'(dut.state_q), 16'(IDLE));
    wait_edge(e0 + 1200);
    check("glitch_nopush", rx_word, 16'h0000);

    // 0x55 with stop bit low, followed by a held-low break.
    e0 = cyc + 1;
    fork
      send_frame(8'h55, 1'b0, -1);
      begin
        wait_edge(e0 + 3 + 1036);
        check("ferr_set", rx_word, 16'h2000);
      end
    join
    idle(300);
    check("break_idle", 16'(dut.state_q), 16'(IDLE));
    check("break_word", rx_word, 16'h2000);
    rx = 1'b1;
    idle(200);
    check("break_end_idle", 16'(dut.state_q), 16'(IDLE));
    clear_errors();
    check("ferr_clr", rx_word, 16'h0000);

    // Nine bytes with no pops; clr_err coincides with the overflow push.
    for (int b = 1; b <= 8; b++) send_frame(8'(b), 1'b1, -1);
    frame_strobe(8'h09, 1'b0, 1'b1);
    idle(3);
    check("ovr_set_wins", rx_word, 16'hC001);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("ovr_head_%0d", i), rx_word, 16'hC000 | 16'(i));
      pop_once();
    end
    check("ovr_drained", rx_word, 16'h4000);
    clear_errors();
    check("ovr_clr", rx_word, 16'h0000);

    // Fill with 0x11..0x18, then 9th byte 0x19 pushed while popping.
    for (int b = 0; b < 8; b++) send_frame(8'(8'h11 + b), 1'b1, -1);
    check("full_head", rx_word, 16'h8011);
    frame_strobe(8'h19, 1'b1, 1'b0);
    idle(3);
    check("pp_full_word", rx_word, 16'h8012);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("pp_head_%0d", i), rx_word, 16'h8000 | 16'(8'h12 + i));
      pop_once();
    end
    check("pp_empty", rx_word, 16'h0000);

    // Reset at T0+500 during 0xA5 (line low during a data bit), then 0x3C
    // pushed while an rd_pop hits the empty FIFO.
    e0 = cyc + 1;
    send_frame(8'hA5, 1'b1, 503);
    reset = 1'b1;
    idle(10);
    check("rst_mid_word", rx_word, 16'h0000);
    reset = 1'b0;
    idle(30);
    check("rst_no_false_start", 16'(dut.state_q), 16'(IDLE));
    check("rst_no_push", rx_word, 16'h0000);
    rx = 1'b1;
    idle(200);
    check("rst_still_empty", rx_word, 16'h0000);
    frame_strobe(8'h3C, 1'b1, 1'b0);
    idle(3);
    check("rst_rx_3c", rx_word, 16'h803C);
    pop_once();
    check("rst_only_one", rx_word, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_io.md
UART_RX_IO -- requirements
Module: uart_rx_io

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 109: sys_clk cycles per bit, giving 115200 baud at 12.5 MHz.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8: receive FIFO entries, power of two, 2..32.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock (sys_clk domain); this is the only clock.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port rx, input, 1 bit: asynchronous serial line from the pin; idles high.
REQ-006 The block SHALL have port rd_pop, input, 1 bit: single-cycle strobe from memory_io_bridge when the CPU reads the UART data address.
REQ-007 The block SHALL have port clr_err, input, 1 bit: single-cycle strobe from the bridge that clears the sticky error flags.
REQ-008 The block SHALL have port rx_word, output, 16 bits: {not_empty, overrun, frame_err, 5'b0, head_byte[7:0]}, driving bridge inM.
REQ-009 The block SHALL have port rx_irq_led, output, 1 bit: high while the FIFO is non-empty (debug LED).

Function
REQ-010 rx SHALL pass through a 2-FF synchronizer; both FFs reset to 1; the synchronized value is rx_s.
REQ-011 The FSM SHALL have four states: IDLE, START, DATA, STOP; the bit counter is ceil(log2(CLKS_PER_BIT)) bits wide and the bit index is 3 bits.
REQ-012 IDLE: on rx_s 1->0 (previous rx_s = 1, current rx_s = 0), the FSM SHALL go to START with cnt cleared; that cycle is T0.
REQ-013 START: at T0+CLKS_PER_BIT/2 (integer division; 54 by default), if rx_s = 1 the FSM SHALL return to IDLE as a glitch, with no push and no error.
REQ-014 START: if rx_s = 0 at that sample, the FSM SHALL go to DATA with index 0.
REQ-015 DATA: bit k (LSB first, k = 0..7) SHALL be sampled at T0+54+109*(k+1); after k = 7 the FSM goes to STOP.
REQ-016 STOP: the stop bit SHALL be sampled at T0+54+109*9 = T0+1035.
REQ-017 A stop bit of 1 SHALL push the byte into the FIFO; a stop bit of 0 SHALL discard the byte and set frame_err.
REQ-018 In either stop-bit case the FSM SHALL return to IDLE.
REQ-019 After a stop error, a held-low line (break) SHALL NOT restart reception until an edge (rx_s high, then low) occurs.
REQ-020 Push latency: a pushed byte SHALL be visible on rx_word[7:0], with rx_word[15] = 1, at T0+1036.
REQ-021 rx_word[7:0] SHALL be the FIFO head (first-word-fall-through) and SHALL read 8'h00 when the FIFO is empty.
REQ-022 rd_pop with not_empty SHALL remove the head; the next entry appears on the next cycle.
REQ-023 rd_pop on an empty FIFO SHALL be ignored.
REQ-024 A push into a full FIFO SHALL drop the byte and set overrun; the stored contents are unchanged.
REQ-025 Simultaneous push and pop with the FIFO full SHALL perform both, leave count unchanged, and SHALL NOT set overrun.
REQ-026 Simultaneous push and pop with the FIFO empty SHALL ignore the pop and accept the push, giving count 1.
REQ-027 Read/write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
REQ-028 overrun and frame_err SHALL be sticky until clr_err.
REQ-029 clr_err in the same cycle as a new error event SHALL leave the flag set, because set wins.
REQ-030 Reception and rd_pop SHALL be independent: popping during a frame SHALL NOT disturb the FSM.

Reset
REQ-031 On reset: FSM = IDLE, cnt = 0, index = 0, shift register = 0.
REQ-032 On reset: FIFO emptied with pointers and count = 0, and both flags cleared.
REQ-033 On reset: rx_word = 16'h0000, rx_irq_led = 0, synchronizer FFs = 1.
REQ-034 Reset asserted mid-frame SHALL abort the frame with no push and no flag.
REQ-035 After a mid-frame reset, reception SHALL resume only on a fresh 1->0 edge after reset is released.

Structure
REQ-036 Package hack_io_pkg SHALL hold: typedef uart_rx_state_t (IDLE, START, DATA, STOP), CLKS_PER_BIT_115200 = 109, and rx_word bit-position constants (NOT_EMPTY_BIT = 15, OVERRUN_BIT = 14, FRAME_ERR_BIT = 13).
REQ-037 The FIFO SHALL be a separate sub-module, sync_fifo (params WIDTH = 8, DEPTH), instantiated once; the FSM and flags stay in uart_rx_io.

Verification
REQ-038 The bench SHALL drive frame 0x41 (8N1, 109 clk/bit) and check rx_word = 16'h8041 at T0+1036, then rd_pop once and check rx_word = 16'h0000.
REQ-039 The bench SHALL drive a 30-cycle low glitch and check the FSM back in IDLE at T0+55, no push, and rx_word = 16'h0000.
REQ-040 The bench SHALL send 0x55 with the stop bit forced low and check rx_word = 16'h2000; then clr_err and check 16'h0000.
REQ-041 The bench SHALL send 9 bytes 0x01..0x09 without popping and check rx_word = 16'hC001; then 8 pops return 0x01..0x08 in order, then rx_word[15] = 0.
REQ-042 The bench SHALL fill the FIFO (8 bytes), then complete a 9th frame with rd_pop asserted in the push cycle, and check no overrun and that the last entry read is the 9th byte.
REQ-043 The bench SHALL assert reset at T0+500 during frame 0xA5, release it, send 0x3C, and check that only 16'h803C is received.
